merge_packetizer: RTL and testbench
===================================

// Module: merge_packetizer
// PURPOSE
//  Downstream stage of the merge router's local output port.
//  - Consumes the headerless stream of summed fp32 BODY flits.
//  - Frames every PKT_LEN flits into one NoC packet: a HEAD flit carrying the destination and
//    length, then PKT_LEN-1 BODY flits, then one TAIL flit.
//  - Sits between merge router local port and the network injection port.
// PARAMETERS
//  PKT_LEN  16  payload flits per packet, legal range 1..65535
//  DST_X    0   destination x coordinate, 8 bits, placed in HEAD payload
//  DST_Y    0   destination y coordinate, 8 bits, placed in HEAD payload
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  data_i      in   `DW    flit from merge router: {type[1:0], fp32[31:0]}; type ignored
//  valid_i     in   1      data_i valid
//  ready_o     out  1      block accepts data_i this cycle
//  data_o      out  `DW    framed flit to network
//  valid_o     out  1      data_o valid
//  ready_i     in   1      network accepts data_o
//  pkt_done_o  out  1      1-cycle pulse when a TAIL is loaded into the output register
//  pkt_cnt_o   out  16     packets completed since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  - Flit format: {type[1:0], payload[`DW-3:0]}. Type field uses `HEAD, `BODY, `TAIL from params.svh.
//  - HEAD payload = {PKT_LEN[15:0], DST_Y[7:0], DST_X[7:0]}.
//  - BODY/TAIL payload = input fp32 bits, passed through unchanged (see CONFIGURATION).
//  - Single output register (data_q, valid_q) drives data_o and valid_o.
//  - out_free = ~valid_q | ready_i. The register loads only when out_free = 1.
//  - If valid_q = 1 and ready_i = 0: data_o and valid_o hold stable; no input is consumed.
//  - Registered outputs: data_o, valid_o, pkt_done_o, pkt_cnt_o.
//  - Combinational output: ready_o = (state == S_BODY) & out_free.
//  - FSM, 2 states, flit counter cnt[15:0]:
//    - S_HEAD: ready_o = 0.
//      - If valid_i & out_free: load HEAD into the register, cnt <= 0, go to S_BODY.
//      - A HEAD is never sent without pending data behind it.
//    - S_BODY: flit accepted when valid_i & ready_o.
//      - If cnt == PKT_LEN-1: load TAIL, pulse pkt_done_o, pkt_cnt_o++, go to S_HEAD.
//      - Otherwise: load BODY, cnt++.
//  - If out_free = 1 and nothing is loaded this cycle, valid_q <= 0.
//  - PKT_LEN = 1: each packet is HEAD then TAIL only; no BODY flit.
//  - Latency:
//    - HEAD appears on data_o 1 cycle after valid_i rises in S_HEAD.
//    - First payload flit appears 1 cycle after that, when ready_i = 1.
//  - Throughput: 1 flit/cycle sustained; PKT_LEN+1 output cycles per packet.
//  - Simultaneous ready_i and load: register drains and reloads in the same cycle; no bubble.
//  - Back-to-back packets: the cycle after TAIL loads, S_HEAD may load the next HEAD.
//  - Reset (any time, including mid-packet):
//    - state = S_HEAD, cnt = 0.
//    - valid_o = 0, data_o = 0, pkt_done_o = 0, pkt_cnt_o = 0.
//    - A partial packet is discarded. No TAIL is emitted for it.
//    - ready_o = 0 during the reset cycle.
// CONFIGURATION
//  - Macro MERGE_PACKETIZER_RELU_EN defined:
//    - BODY/TAIL payload = bit31 ? 32'h0000_0000 : fp32.
//    - Negative values and -0.0 become +0.0. NaN with sign bit 1 also becomes +0.0.
//    - HEAD payload is unaffected.
//  - Macro undefined: payload passes through bit-exact.
//  - Latency and handshake are identical in both builds.
// TESTING
//  1. PKT_LEN=4, DST_X=2, DST_Y=3, ready_i=1, 4 flits 1.0,2.0,3.0,4.0 back-to-back
//     -> HEAD payload 0x0004_0302, BODY 3F800000, BODY 40000000, BODY 40400000, TAIL 40800000;
//        pkt_done_o pulses once; pkt_cnt_o=1.
//  2. PKT_LEN=1, 3 input flits
//     -> HEAD,TAIL x3 with no BODY; pkt_cnt_o=3.
//  3. PKT_LEN=4, ready_i low for 5 cycles after HEAD
//     -> data_o/valid_o stable, ready_o=0, no input consumed; stream resumes intact.
//  4. rst asserted after 2 of 4 flits accepted
//     -> next cycle valid_o=0, pkt_cnt_o=0; next packet starts with a fresh HEAD.
//  5. RELU_EN defined, input -2.5 (C0200000) and -0.0 (80000000)
//     -> payload 00000000 for both; undefined build -> C0200000 and 80000000.
//  6. 2^16 packets with PKT_LEN=1
//     -> pkt_cnt_o wraps to 0 on the 65536th TAIL.

Source files
------------

// File: rtl/merge_packetizer.sv
// Frames a headerless fp32 flit stream into HEAD / BODY... / TAIL NoC packets of PKT_LEN flits.
// Optional macro MERGE_PACKETIZER_RELU_EN clamps negative payloads (sign bit set) to +0.0.

`ifndef DW
`define DW 34
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module merge_packetizer #(
  parameter int unsigned PKT_LEN = 16,
  parameter logic [7:0]  DST_X   = 8'd0,
  parameter logic [7:0]  DST_Y   = 8'd0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [`DW-1:0] data_i,
  input  logic           valid_i,
  output logic           ready_o,
  output logic [`DW-1:0] data_o,
  output logic           valid_o,
  input  logic           ready_i,
  output logic           pkt_done_o,
  output logic [15:0]    pkt_cnt_o
);

  typedef enum logic {S_HEAD, S_BODY} state_t;

  localparam logic [15:0]    LAST         = 16'(PKT_LEN - 1);
  localparam logic [`DW-3:0] HEAD_PAYLOAD = {16'(PKT_LEN), DST_Y, DST_X};

  state_t         state, state_n;
  logic [15:0]    cnt, cnt_n;
  logic [`DW-1:0] data_q, data_n;
  logic           valid_q, valid_n;
  logic           done_q, done_n;
  logic [15:0]    pkt_cnt_q, pkt_cnt_n;
  logic           out_free;
  logic [`DW-3:0] payload;
  logic           unused_type;

  assign unused_type = ^data_i[`DW-1:`DW-2];

`ifdef MERGE_PACKETIZER_RELU_EN
  assign payload = data_i[`DW-3] ? '0 : data_i[`DW-3:0];
`else
  assign payload = data_i[`DW-3:0];
`endif

  assign out_free   = ~valid_q | ready_i;
  // Gated by rst so nothing is seen as accepted while the FSM is being cleared.
  assign ready_o    = ~rst & (state == S_BODY) & out_free;
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign pkt_done_o = done_q;
  assign pkt_cnt_o  = pkt_cnt_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    data_n    = data_q;
    valid_n   = valid_q;
    done_n    = 1'b0;
    pkt_cnt_n = pkt_cnt_q;
    if (out_free) valid_n = 1'b0;
    case (state)
      S_HEAD: begin
        if (valid_i && out_free) begin
          data_n  = {`HEAD, HEAD_PAYLOAD};
          valid_n = 1'b1;
          cnt_n   = '0;
          state_n = S_BODY;
        end
      end
      S_BODY: begin
        if (valid_i && ready_o) begin
          valid_n = 1'b1;
          if (cnt == LAST) begin
            data_n    = {`TAIL, payload};
            done_n    = 1'b1;
            pkt_cnt_n = pkt_cnt_q + 16'd1;
            state_n   = S_HEAD;
          end else begin
            data_n = {`BODY, payload};
            cnt_n  = cnt + 16'd1;
          end
        end
      end
      default: state_n = S_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HEAD;
      cnt       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      done_q    <= done_n;
      pkt_cnt_q <= pkt_cnt_n;
    end
  end

endmodule

// File: tb/tb_merge_packetizer.sv
// Directed self-checking bench for merge_packetizer: PKT_LEN=4 (dst 2,3) and PKT_LEN=1 instances.

`ifndef DW
`define DW 34
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module tb_merge_packetizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [`DW-1:0] din_a = '0, data_a;
  logic           vin_a = 1'b0, rdy_a = 1'b1, ready_a, valid_a, done_a;
  logic [15:0]    cnt_a;

  logic [`DW-1:0] din_b = '0, data_b;
  logic           vin_b = 1'b0, rdy_b = 1'b1, ready_b, valid_b, done_b;
  logic [15:0]    cnt_b;

  merge_packetizer #(.PKT_LEN(4), .DST_X(8'd2), .DST_Y(8'd3)) dut_a (
    .clk(clk), .rst(rst), .data_i(din_a), .valid_i(vin_a), .ready_o(ready_a),
    .data_o(data_a), .valid_o(valid_a), .ready_i(rdy_a),
    .pkt_done_o(done_a), .pkt_cnt_o(cnt_a));

  merge_packetizer #(.PKT_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .data_i(din_b), .valid_i(vin_b), .ready_o(ready_b),
    .data_o(data_b), .valid_o(valid_b), .ready_i(rdy_b),
    .pkt_done_o(done_b), .pkt_cnt_o(cnt_b));

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef MERGE_PACKETIZER_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // One PKT_LEN=4 packet on dut_a, optional output stall right after the HEAD.
  task automatic pkt_a(input logic [31:0] v [4], input int unsigned stall,
                       input logic [15:0] cnt_exp);
    din_a = {2'b00, v[0]};
    vin_a = 1'b1;
    rdy_a = 1'b1;
    #1;
    check("a_ready_in_head", ready_a, 1'b0);
    step();
    check("a_head", data_a, {`HEAD, 32'h0004_0302});
    check("a_head_valid", valid_a, 1'b1);
    if (stall != 0) begin
      rdy_a = 1'b0;
      #1;
      for (int unsigned s = 0; s < stall; s++) begin
        check("a_stall_ready", ready_a, 1'b0);
        step();
        check("a_stall_data", data_a, {`HEAD, 32'h0004_0302});
        check("a_stall_valid", valid_a, 1'b1);
      end
      rdy_a = 1'b1;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      din_a = {2'b00, v[i]};
      #1;
      check("a_ready_body", ready_a, 1'b1);
      step();
      check("a_flit", data_a, {(i == 3) ? `TAIL : `BODY, relu(v[i])});
      check("a_flit_valid", valid_a, 1'b1);
      check("a_done", done_a, (i == 3));
    end
    check("a_pkt_cnt", cnt_a, cnt_exp);
    vin_a = 1'b0;
    step();
    check("a_idle_valid", valid_a, 1'b0);
    check("a_idle_done", done_a, 1'b0);
  endtask

  logic [31:0] v [4];
  logic [31:0] vb [3];

  initial begin
    step();
    step();
    check("rst_valid", valid_a, 1'b0);
    check("rst_data", data_a, '0);
    check("rst_done", done_a, 1'b0);
    check("rst_cnt", cnt_a, 16'd0);
    check("rst_ready", ready_a, 1'b0);
    rst = 1'b0;

    v = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    pkt_a(v, 0, 16'd1);

    v = '{32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    pkt_a(v, 5, 16'd2);

    v = '{32'hC020_0000, 32'h8000_0000, 32'hFFC0_0000, 32'h4040_0000};
    pkt_a(v, 0, 16'd3);

    // PKT_LEN=1: HEAD then TAIL, back-to-back.
    vb = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000};
    vin_b = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      din_b = {2'b00, vb[i]};
      #1;
      check("b_ready_in_head", ready_b, 1'b0);
      step();
      check("b_head", data_b, {`HEAD, 32'h0001_0000});
      check("b_head_done", done_b, 1'b0);
      check("b_ready_body", ready_b, 1'b1);
      step();
      check("b_tail", data_b, {`TAIL, relu(vb[i])});
      check("b_done", done_b, 1'b1);
      check("b_pkt_cnt", cnt_b, 16'(i + 1));
    end
    vin_b = 1'b0;
    step();
    check("b_idle_valid", valid_b, 1'b0);
    vin_b = 1'b1;
    for (int unsigned i = 0; i < 400; i++) step();
    vin_b = 1'b0;
    check("b_pkt_cnt_long", cnt_b, 16'd203);

    // Reset mid-packet after two payload flits were accepted.
    din_a = {2'b00, 32'h4110_0000};
    vin_a = 1'b1;
    step();
    check("r_head", data_a, {`HEAD, 32'h0004_0302});
    step();
    check("r_body0", data_a, {`BODY, 32'h4110_0000});
    din_a = {2'b00, 32'h4120_0000};
    step();
    check("r_body1", data_a, {`BODY, 32'h4120_0000});
    rst = 1'b1;
    #1;
    check("r_ready_in_rst", ready_a, 1'b0);
    step();
    rst   = 1'b0;
    vin_a = 1'b0;
    check("r_valid", valid_a, 1'b0);
    check("r_data", data_a, '0);
    check("r_cnt", cnt_a, 16'd0);
    check("r_done", done_a, 1'b0);
    v = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    pkt_a(v, 0, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
